// File: rtl/difftest_commit_ctrl_if.sv
// WB-to-checker commit handshake bundle: commit records in from WB, head record out to the checker.
interface difftest_commit_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_WIDTH-1:0] wb_pc;
    logic [DATA_WIDTH-1:0] wb_instr;
    logic                  wb_branch_taken;
    logic [DATA_WIDTH-1:0] wb_branch_pc;
    logic                  wb_skip;

    logic                  dt_valid;
    logic                  dt_ready;
    logic [DATA_WIDTH-1:0] dt_pc;
    logic [DATA_WIDTH-1:0] dt_instr;
    logic [DATA_WIDTH-1:0] dt_next_pc;
    logic                  dt_skip;

    modport master (
        output wb_valid, wb_pc, wb_instr, wb_branch_taken, wb_branch_pc, wb_skip, dt_ready,
        input  wb_ready, dt_valid, dt_pc, dt_instr, dt_next_pc, dt_skip
    );

    modport slave (
        input  wb_valid, wb_pc, wb_instr, wb_branch_taken, wb_branch_pc, wb_skip, dt_ready,
        output wb_ready, dt_valid, dt_pc, dt_instr, dt_next_pc, dt_skip
    );
endinterface

// File: rtl/difftest_commit_ctrl.sv
// Commit-record queue from WB to the difftest checker; next-PC is computed at enqueue.
// Records show on dt_* the cycle after enqueue; wb_ready drops when full, draining or halted.
module difftest_commit_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] EBREAK     = DATA_WIDTH'(32'h00100073)
) (
    input  logic                  clk,
    input  logic                  rst,
    difftest_commit_ctrl_if.slave bus,
    output logic [63:0]           commit_cnt,
    output logic                  halt,
    output logic                  overflow
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] next_pc;
        logic                  skip;
    } rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    rec_t             mem [DEPTH];
    rec_t             wr_rec;
    rec_t             head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             enq;
    logic             deq;

    assign enq = bus.wb_valid && bus.wb_ready;
    assign deq = bus.dt_valid && bus.dt_ready;

    always_comb begin
        wr_rec.pc      = bus.wb_pc;
        wr_rec.instr   = bus.wb_instr;
        wr_rec.next_pc = bus.wb_branch_taken ? bus.wb_branch_pc : bus.wb_pc + DATA_WIDTH'(4);
        wr_rec.skip    = bus.wb_skip;
    end

    always_comb begin
        count_nxt = count;
        case ({enq, deq})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN looks at the post-dequeue occupancy so HALT lands on the edge of the last dequeue.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (enq && bus.wb_instr == EBREAK) state_nxt = DRAIN;
            DRAIN:   if (count_nxt == '0) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        bus.wb_ready = 1'b0;
        bus.dt_valid = 1'b0;
        halt         = 1'b0;
        case (state)
            RUN: begin
                bus.wb_ready = (count != FULL_CNT);
                bus.dt_valid = (count != '0);
            end
            DRAIN:   bus.dt_valid = (count != '0);
            HALT:    halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            commit_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                commit_cnt <= commit_cnt + 64'd1;
            end
            count <= count_nxt;
            if (bus.wb_valid && state != RUN) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; dt_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.dt_pc      = head.pc;
    assign bus.dt_instr   = head.instr;
    assign bus.dt_next_pc = head.next_pc;
    assign bus.dt_skip    = head.skip;
endmodule

// File: tb/tb_difftest_commit_ctrl.sv
// Directed plus randomized bench for difftest_commit_ctrl against a queue-based commit model.
module tb_difftest_commit_ctrl;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] commit_cnt;
    logic        halt;
    logic        overflow;

    difftest_commit_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    difftest_commit_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EBREAK(EBREAK)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .commit_cnt (commit_cnt),
        .halt       (halt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] next_pc;
        logic        skip;
    } rec_t;

    // Reference: queue of pending commits, mode 0=accepting, 1=ebreak seen, 2=halted.
    rec_t            q[$];
    int              m_mode;
    longint unsigned m_cnt;
    bit              m_ovf;
    int              n_chk;
    int              n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
    endtask

    // Entered just after a negedge with inputs driven; leaves at the next negedge.
    task automatic cycle(output bit acc);
        bit   exp_rdy;
        bit   exp_vld;
        bit   deq;
        rec_t r;
        exp_rdy = (m_mode == 0) && (q.size() < DEPTH);
        exp_vld = (m_mode != 2) && (q.size() != 0);
        #1;
        check("wb_ready", bus.wb_ready, exp_rdy);
        check("dt_valid", bus.dt_valid, exp_vld);
        if (exp_vld) begin
            check("dt_pc", bus.dt_pc, q[0].pc);
            check("dt_instr", bus.dt_instr, q[0].instr);
            check("dt_next_pc", bus.dt_next_pc, q[0].next_pc);
            check("dt_skip", bus.dt_skip, q[0].skip);
        end
        check("commit_cnt", commit_cnt, m_cnt);
        check("halt", halt, m_mode == 2);
        check("overflow", overflow, m_ovf);
        @(posedge clk);
        acc = bus.wb_valid && exp_rdy;
        deq = exp_vld && bus.dt_ready;
        if (!rst) begin
            model_reset();
            acc = 1'b0;
        end else begin
            if (bus.wb_valid && m_mode != 0) m_ovf = 1'b1;
            if (deq) begin
                q.delete(0);
                m_cnt++;
            end
            if (acc) begin
                r.pc      = bus.wb_pc;
                r.instr   = bus.wb_instr;
                r.next_pc = bus.wb_branch_taken ? bus.wb_branch_pc : bus.wb_pc + 32'd4;
                r.skip    = bus.wb_skip;
                q.push_back(r);
            end
            if (m_mode == 1 && q.size() == 0) m_mode = 2;
            else if (acc && bus.wb_instr == EBREAK) m_mode = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit dtr, input int n);
        bit acc;
        bus.wb_valid = 1'b0;
        bus.dt_ready = dtr;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input bit taken,
                        input logic [31:0] bpc, input bit skip, input bit dtr);
        bit acc;
        bit done;
        done = 1'b0;
        bus.wb_valid        = 1'b1;
        bus.wb_pc           = pc;
        bus.wb_instr        = instr;
        bus.wb_branch_taken = taken;
        bus.wb_branch_pc    = bpc;
        bus.wb_skip         = skip;
        bus.dt_ready        = dtr;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle(acc);
            done = acc;
        end
        if (!done) check("push_timeout", 64'd0, 64'd1);
        bus.wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(1'b0, 1);
        rst = 1'b1;
    endtask

    initial begin
        bit          acc;
        bit          pending;
        logic [31:0] pc;
        n_chk  = 0;
        n_fail = 0;
        bus.wb_valid        = 1'b0;
        bus.wb_pc           = '0;
        bus.wb_instr        = '0;
        bus.wb_branch_taken = 1'b0;
        bus.wb_branch_pc    = '0;
        bus.wb_skip         = 1'b0;
        bus.dt_ready        = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        check("rst_dt_valid", bus.dt_valid, 1'b0);
        check("rst_wb_ready", bus.wb_ready, 1'b1);
        check("rst_commit_cnt", commit_cnt, 64'd0);
        check("rst_halt", halt, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Single commit, then branch target and PC wrap.
        push(32'h8000_0000, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b1, 2);
        #1 check("t1_commit_cnt", commit_cnt, 64'd1);
        push(32'h8000_0010, 32'h0000_006f, 1'b1, 32'h8000_0100, 1'b1, 1'b0);
        #1 check("t2_branch_next", bus.dt_next_pc, 32'h8000_0100);
        idle(1'b1, 1);
        push(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0);
        #1 check("t2_wrap_next", bus.dt_next_pc, 32'h0000_0000);
        idle(1'b1, 2);

        // Fill under backpressure, then full with a simultaneous dequeue.
        for (int i = 0; i < 4; i++) push(32'h8000_1000 + 32'(i * 4), 32'h13 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_pc    = 32'h8000_1010;
        bus.wb_instr = 32'h0000_0113;
        #1 check("t3_full_ready", bus.wb_ready, 1'b0);
        cycle(acc);
        bus.dt_ready = 1'b1;
        #1 check("t4_full_deq_ready", bus.wb_ready, 1'b0);
        cycle(acc);
        cycle(acc);
        check("t4_accept_after_deq", acc, 1'b1);
        idle(1'b1, 6);
        #1 check("t3_overflow", overflow, 1'b0);

        // ebreak drain and halt, then a stray commit sets overflow.
        do_reset();
        push(32'h8000_2000, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'h8000_2004, 32'h0000_0093, 1'b0, 32'h0, 1'b0, 1'b1);
        push(32'h8000_2008, EBREAK, 1'b0, 32'h0, 1'b0, 1'b1);
        #1 check("t5_ready_after_ebreak", bus.wb_ready, 1'b0);
        idle(1'b1, 2);
        #1 check("t5_halt", halt, 1'b1);
        check("t5_commit_cnt", commit_cnt, 64'd3);
        bus.wb_valid = 1'b1;
        cycle(acc);
        idle(1'b1, 1);
        #1 check("t5_overflow", overflow, 1'b1);

        // Reset while draining with two records left.
        do_reset();
        push(32'h8000_3000, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0);
        push(32'h8000_3004, 32'h0000_0013, 1'b0, 32'h0, 1'b0, 1'b0);
        push(32'h8000_3008, EBREAK, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 1);
        do_reset();
        #1 check("t6_dt_valid", bus.dt_valid, 1'b0);
        check("t6_halt", halt, 1'b0);
        check("t6_commit_cnt", commit_cnt, 64'd0);
        check("t6_wb_ready", bus.wb_ready, 1'b1);

        // Randomized traffic; WB holds a record until it is accepted.
        pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0 || (m_mode == 2 && $urandom_range(0, 9) == 0)) ? 1'b0 : 1'b1;
            if (!pending && $urandom_range(0, 9) < 6) begin
                pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
                bus.wb_pc           = pc;
                bus.wb_instr        = ($urandom_range(0, 11) == 0) ? EBREAK : $urandom();
                bus.wb_branch_taken = $urandom_range(0, 1) == 1;
                bus.wb_branch_pc    = $urandom() & 32'hFFFF_FFFC;
                bus.wb_skip         = $urandom_range(0, 3) == 0;
                pending             = 1'b1;
            end
            bus.wb_valid = pending;
            bus.dt_ready = $urandom_range(0, 9) < 6;
            cycle(acc);
            if (acc || !rst) pending = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/difftest_commit_ctrl.md
Name: difftest_commit_ctrl

Overview:
- Sequences committed-instruction records from the WB stage into the DPI difftest checker.
- Queues commits in a small FIFO, computes the architectural next-PC at enqueue, and applies a valid/ready handshake toward the checker so the simulator side can stall.
- Drains and halts cleanly on ebreak.
- Sits between WB and the Difftest register stage; exists only under `DIFFTEST`.

Parameters:
- DATA_WIDTH, 32, width of PC/instruction/next-PC fields.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- EBREAK, 32'h00100073, instruction encoding that triggers drain/halt.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low: rst==0 at posedge resets.
- wb_valid  in  1  WB presents a committed instruction.
- wb_ready  out  1  controller accepts; equals (state==RUN && count<DEPTH).
- wb_pc  in  DATA_WIDTH  committed PC.
- wb_instr  in  DATA_WIDTH  committed instruction.
- wb_branch_taken  in  1  control transfer taken.
- wb_branch_pc  in  DATA_WIDTH  transfer target.
- wb_skip  in  1  MMIO access; checker copies state instead of comparing.
- dt_valid  out  1  head record available.
- dt_ready  in  1  checker consumes head.
- dt_pc  out  DATA_WIDTH  head PC.
- dt_instr  out  DATA_WIDTH  head instruction.
- dt_next_pc  out  DATA_WIDTH  head next PC.
- dt_skip  out  1  head skip flag.
- commit_cnt  out  64  records dequeued since reset.
- halt  out  1  ebreak committed and FIFO drained.
- overflow  out  1  sticky protocol error.

Behaviour:
- Reset (rst==0):
  - rd_ptr, wr_ptr and count go to 0; state goes to RUN.
  - dt_valid=0, commit_cnt=0, halt=0, overflow=0.
  - FIFO storage is not cleared; dt_pc/dt_instr/dt_next_pc/dt_skip are don't-care while dt_valid=0.
  - Reset mid-operation discards all queued records with no dequeue.
- Enqueue:
  - Occurs when wb_valid && wb_ready.
  - Writes {wb_pc, wb_instr, next, wb_skip} at wr_ptr, where next = wb_branch_taken ? wb_branch_pc : wb_pc + 4 (modulo 2^DATA_WIDTH; PC=FFFFFFFC gives 00000000).
  - wr_ptr increments modulo DEPTH.
- Dequeue:
  - Occurs when dt_valid && dt_ready.
  - rd_ptr increments modulo DEPTH; commit_cnt increments by 1 and wraps.
- Output timing:
  - dt_valid = (count != 0).
  - dt_* present mem[rd_ptr] in first-word-fall-through fashion.
  - A record enqueued at edge N is visible on dt_* in the cycle after edge N; no same-cycle bypass.
- count update: +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue and dequeue.
- Full (count==DEPTH):
  - wb_ready=0 even if dt_ready=1 in the same cycle; there is no pass-through on full.
  - WB must hold its inputs stable until accepted.
- Empty (count==0): dt_valid=0; dt_ready is ignored.
- dt_valid/dt_* stay stable while dt_valid && !dt_ready.
- FSM:
  - RUN: if an enqueue occurs with wb_instr==EBREAK, go to DRAIN at that edge. The ebreak record itself is queued.
  - DRAIN: wb_ready=0. Dequeues continue. When count==0 (evaluated after that cycle's dequeue), go to HALT.
  - HALT: halt=1 (registered; asserted the cycle after the final dequeue). wb_ready=0, dt_valid=0. Only reset leaves HALT.
- overflow:
  - Set to 1 at the edge after any cycle with wb_valid=1 while state != RUN (an instruction after ebreak).
  - Cleared only by reset.
  - Normal full backpressure in RUN does not set it.

Test Plan:
1. Reset then one commit: PC=80000000, instr=00000013, taken=0, dt_ready=1 → next cycle dt_valid=1, dt_next_pc=80000004; after the dequeue edge, commit_cnt=1 and dt_valid=0.
2. Branch plus wrap: PC=80000010, taken=1, target=80000100 → dt_next_pc=80000100. Separately, PC=FFFFFFFC with taken=0 → dt_next_pc=00000000.
3. Backpressure: dt_ready=0, push 5 back-to-back records → 4 accepted, wb_ready=0 from the cycle after the 4th; raise dt_ready → records leave in order, one per cycle, and the 5th is accepted once count<4. overflow stays 0.
4. Full with simultaneous dequeue: count=4, dt_ready=1, wb_valid=1 → wb_ready=0 that cycle, count becomes 3, the new record is accepted the following cycle.
5. ebreak: queue 2 records followed by 00100073 with dt_ready=1 → wb_ready drops after the ebreak enqueue; halt=1 the cycle after the 3rd dequeue; commit_cnt=3. Asserting wb_valid afterwards → overflow=1.
6. Reset mid-drain: rst=0 during DRAIN with count=2 → next cycle dt_valid=0, halt=0, commit_cnt=0, wb_ready=1.
